// File: rtl/clk_period_meter.sv
// Measures the period and high time of a slow, asynchronous clock in cycles of clk.
// Reports lock against an expected half-period and flags a stalled input with a timeout.
module clk_period_meter #(
  parameter int N       = 50000000,
  parameter int WIDTH   = 32,
  parameter int TOL     = 2,
  parameter int TIMEOUT = 200000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic             enable,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FIRST,
    MEASURE
  } state_t;

  // Tolerance window bounds, clamped at zero and widened by one bit so the
  // lower bound never wraps for small N.
  localparam int PER_LO_I  = (2 * N > TOL) ? 2 * N - TOL : 0;
  localparam int HIGH_LO_I = (N > TOL) ? N - TOL : 0;
  localparam logic [WIDTH:0] PER_LO  = (WIDTH + 1)'(PER_LO_I);
  localparam logic [WIDTH:0] PER_HI  = (WIDTH + 1)'(2 * N + TOL);
  localparam logic [WIDTH:0] HIGH_LO = (WIDTH + 1)'(HIGH_LO_I);
  localparam logic [WIDTH:0] HIGH_HI = (WIDTH + 1)'(N + TOL);
  localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);

  state_t           state;
  logic             s1, s2, s3;
  logic             rise, fall;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] hpend;
  logic             in_tol;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  assign in_tol = ({1'b0, cnt} >= PER_LO) && ({1'b0, cnt} <= PER_HI) &&
                  ({1'b0, hpend} >= HIGH_LO) && ({1'b0, hpend} <= HIGH_HI);

  // s3 only exists to form the edge pulses; it adds the same delay to rise and fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // which is what turns s1/s2/s3 into a real shift chain.
      s1 <= clk_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hpend      <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!enable) begin
        state   <= IDLE;
        cnt     <= '0;
        locked  <= 1'b0;
        timeout <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            state <= WAIT_FIRST;
          end
          WAIT_FIRST, MEASURE: begin
            if (rise) begin
              cnt <= WIDTH'(1);
            end else if (cnt != TIMEOUT_C) begin
              cnt <= cnt + 1'b1;
            end

            if (fall && state == MEASURE) begin
              hpend <= cnt;
            end

            // A rise landing on the saturation cycle still counts as a valid edge.
            if (rise) begin
              timeout <= 1'b0;
              state   <= MEASURE;
              if (state == MEASURE) begin
                period     <= cnt;
                high_time  <= hpend;
                meas_valid <= 1'b1;
                locked     <= in_tol;
              end
            end else if (cnt == TIMEOUT_C) begin
              timeout <= 1'b1;
              locked  <= 1'b0;
              state   <= WAIT_FIRST;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: clk_in edges are timestamped as they are driven and a
// timestamp-based model predicts every output on every cycle.
module tb_clk_period_meter;

  localparam int N       = 5;
  localparam int WIDTH   = 8;
  localparam int TOL     = 1;
  localparam int TIMEOUT = 40;
  localparam int LAT     = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             clk_in;
  logic             enable;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             timeout;

  clk_period_meter #(
    .N(N), .WIDTH(WIDTH), .TOL(TOL), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .clk_in(clk_in), .enable(enable),
    .period(period), .high_time(high_time), .meas_valid(meas_valid),
    .locked(locked), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Cycle numbers at which each driven clk_in edge becomes visible to the meter.
  int rise_q[$];
  int fall_q[$];

  bit running;
  bit meas;
  int r_ref;
  int hpend_m;
  bit exp_mv;
  bit exp_locked;
  bit exp_to;
  int exp_period;
  int exp_high;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit in_tol(input int p, input int h);
    return (p >= 2 * N - TOL) && (p <= 2 * N + TOL) && (h >= N - TOL) && (h <= N + TOL);
  endfunction

  function automatic int sat(input int v);
    return (v > TIMEOUT) ? TIMEOUT : v;
  endfunction

  task automatic model_reset();
    running    = 1'b0;
    meas       = 1'b0;
    r_ref      = 0;
    hpend_m    = 0;
    exp_mv     = 1'b0;
    exp_locked = 1'b0;
    exp_to     = 1'b0;
    exp_period = 0;
    exp_high   = 0;
    rise_q.delete();
    fall_q.delete();
  endtask

  // r_ref is the edge after which the running count reads 1, so the count
  // seen at edge c is c - r_ref (saturating at TIMEOUT).
  task automatic model_step(input bit en_s, input bit rst_s);
    bit has_r = 1'b0;
    bit has_f = 1'b0;
    while (rise_q.size() > 0 && rise_q[0] < cyc) void'(rise_q.pop_front());
    while (fall_q.size() > 0 && fall_q[0] < cyc) void'(fall_q.pop_front());
    if (rise_q.size() > 0 && rise_q[0] == cyc) begin has_r = 1'b1; void'(rise_q.pop_front()); end
    if (fall_q.size() > 0 && fall_q[0] == cyc) begin has_f = 1'b1; void'(fall_q.pop_front()); end
    exp_mv = 1'b0;
    if (!rst_s) begin
      model_reset();
    end else if (!en_s) begin
      running    = 1'b0;
      meas       = 1'b0;
      exp_locked = 1'b0;
      exp_to     = 1'b0;
    end else if (!running) begin
      running = 1'b1;
      meas    = 1'b0;
      r_ref   = cyc + 1;
    end else begin
      if (has_f && meas) hpend_m = sat(cyc - r_ref);
      if (has_r) begin
        if (meas) begin
          exp_mv     = 1'b1;
          exp_period = cyc - r_ref;
          exp_high   = hpend_m;
          exp_locked = in_tol(exp_period, exp_high);
        end
        meas   = 1'b1;
        exp_to = 1'b0;
        r_ref  = cyc;
      end else if (cyc - r_ref >= TIMEOUT) begin
        exp_to     = 1'b1;
        exp_locked = 1'b0;
        meas       = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    check("meas_valid", meas_valid, exp_mv);
    check("timeout", timeout, exp_to);
    check("locked", locked, exp_locked);
    check("period", period, exp_period);
    check("high_time", high_time, exp_high);
  endtask

  task automatic tick();
    bit en_s;
    bit rst_s;
    en_s = enable;
    @(posedge clk);
    rst_s = rst;
    #1;
    cyc++;
    model_step(en_s, rst_s);
    check_all();
  endtask

  task automatic drive(input logic v);
    if (v !== clk_in) begin
      clk_in = v;
      if (v) rise_q.push_back(cyc + LAT);
      else   fall_q.push_back(cyc + LAT);
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    drive(1'b1);
    repeat (hi) tick();
    drive(1'b0);
    repeat (lo) tick();
  endtask

  task automatic release_reset();
    rst = 1'b1;
    model_reset();
    if (clk_in) rise_q.push_back(cyc + LAT);
  endtask

  task automatic async_reset_now();
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_all();
  endtask

  initial begin
    int c0;
    int seen;
    int hi;
    int lo;

    rst    = 1'b1;
    clk_in = 1'b0;
    enable = 1'b1;
    model_reset();
    #1 rst = 1'b0;
    #1 check_all();

    // Reset held while clk_in toggles, then release: nothing until the second rise.
    repeat (3) pulse(4, 3);
    release_reset();

    // clk_in at the nominal divider rate.
    repeat (6) pulse(5, 5);
    check("div_period", period, 10);
    check("div_high", high_time, 5);
    check("div_locked", locked, 1);

    // Off-rate input, then the upper edge of the tolerance window.
    repeat (3) pulse(7, 7);
    check("slow_period", period, 14);
    check("slow_high", high_time, 7);
    check("slow_locked", locked, 0);
    repeat (3) pulse(5, 6);
    check("edge_period", period, 11);
    check("edge_high", high_time, 5);
    check("edge_locked", locked, 1);

    // Stall clk_in low after a rise and time the timeout.
    c0 = cyc;
    drive(1'b1);
    repeat (5) tick();
    drive(1'b0);
    seen = -1;
    for (int i = 0; i < 60 && seen < 0; i++) begin
      tick();
      if (timeout === 1'b1) seen = cyc - c0;
    end
    check("timeout_latency", seen, LAT + TIMEOUT);
    check("timeout_locked", locked, 0);
    repeat (5) tick();
    repeat (3) pulse(5, 5);
    check("restart_locked", locked, 1);
    check("restart_timeout", timeout, 0);

    // One-cycle disable mid-period, coinciding with a registered rise.
    drive(1'b1);
    repeat (2) tick();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    check("dis_locked", locked, 0);
    check("dis_period", period, 10);
    repeat (3) tick();
    drive(1'b0);
    repeat (5) tick();
    repeat (3) pulse(5, 5);
    check("relock", locked, 1);

    // Random high/low lengths, occasionally long enough to time out.
    for (int k = 0; k < 30; k++) begin
      hi = $urandom_range(3, 8);
      lo = ($urandom_range(0, 5) == 0) ? $urandom_range(30, 45) : $urandom_range(3, 8);
      pulse(hi, lo);
    end

    // Asynchronous reset in the middle of a high phase.
    repeat (3) pulse(5, 5);
    drive(1'b1);
    repeat (2) tick();
    async_reset_now();
    check("async_period", period, 0);
    check("async_locked", locked, 0);
    repeat (2) tick();
    drive(1'b0);
    tick();
    release_reset();
    tick();

    // A rise landing exactly when the count saturates is a measurement, not a timeout.
    pulse(5, 35);
    drive(1'b1);
    repeat (LAT) tick();
    check("coinc_mv", meas_valid, 1);
    check("coinc_period", period, TIMEOUT);
    check("coinc_timeout", timeout, 0);
    repeat (2) tick();
    drive(1'b0);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
